// File: rtl/xosera_bus_if_if.sv
// Bus pin and register-file signal bundle for xosera_bus_if.
// slave faces the front end; master faces the pads and the core.
interface xosera_bus_if_if #(
   parameter int DATA_W   = 8,
   parameter int REGNUM_W = 4
);
   logic                bus_cs_n_i;
   logic                bus_rd_nwr_i;
   logic                bus_bytesel_i;
   logic [REGNUM_W-1:0] bus_reg_num_i;
   logic [DATA_W-1:0]   bus_data_i;
   logic [DATA_W-1:0]   bus_data_o;
   logic                bus_out_ena_o;
   logic                bus_dtack_o;
   logic                reg_wr_o;
   logic                reg_rd_o;
   logic [REGNUM_W-1:0] reg_num_o;
   logic                reg_bytesel_o;
   logic [DATA_W-1:0]   reg_data_o;
   logic                reg_rd_ack_i;
   logic [DATA_W-1:0]   reg_rd_data_i;
   logic                bus_timeout_o;

   modport slave (
      input  bus_cs_n_i, bus_rd_nwr_i, bus_bytesel_i,
      input  bus_reg_num_i, bus_data_i,
      input  reg_rd_ack_i, reg_rd_data_i,
      output bus_data_o, bus_out_ena_o, bus_dtack_o,
      output reg_wr_o, reg_rd_o, reg_num_o,
      output reg_bytesel_o, reg_data_o, bus_timeout_o
   );

   modport master (
      output bus_cs_n_i, bus_rd_nwr_i, bus_bytesel_i,
      output bus_reg_num_i, bus_data_i,
      output reg_rd_ack_i, reg_rd_data_i,
      input  bus_data_o, bus_out_ena_o, bus_dtack_o,
      input  reg_wr_o, reg_rd_o, reg_num_o,
      input  reg_bytesel_o, reg_data_o, bus_timeout_o
   );
endinterface

// File: rtl/xosera_bus_if.sv
// m68k host-bus front end: strobe sync, access FSM, DTACK/output enable.
// Define XOSERA_BUS_TIMEOUT_EN to add the read-ack timeout.
module xosera_bus_if #(
   parameter int DATA_W         = 8,
   parameter int REGNUM_W       = 4,
   parameter int SYNC_STAGES    = 2,
   parameter int TIMEOUT_CYCLES = 255
) (
   input logic            clk,
   input logic            reset_n_i,
   xosera_bus_if_if.slave bus
);

   localparam logic [1:0] IDLE    = 2'd0;
   localparam logic [1:0] SETTLE  = 2'd1;
   localparam logic [1:0] WAIT_RD = 2'd2;
   localparam logic [1:0] ACK     = 2'd3;

   logic [SYNC_STAGES-1:0] cs_n_q;
   logic [SYNC_STAGES-1:0] rd_nwr_q;
   logic [SYNC_STAGES-1:0] bytesel_q;
   logic [REGNUM_W-1:0]    num_q [SYNC_STAGES];
   logic [DATA_W-1:0]      din_q [SYNC_STAGES];
   logic                   cs_s;

   always_ff @(posedge clk or negedge reset_n_i) begin
      if (!reset_n_i) begin
         cs_n_q    <= '1;
         rd_nwr_q  <= '0;
         bytesel_q <= '0;
         for (int i = 0; i < SYNC_STAGES; i++) begin
            num_q[i] <= '0;
            din_q[i] <= '0;
         end
      end else begin
         cs_n_q    <= {cs_n_q[SYNC_STAGES-2:0], bus.bus_cs_n_i};
         rd_nwr_q  <= {rd_nwr_q[SYNC_STAGES-2:0], bus.bus_rd_nwr_i};
         bytesel_q <= {bytesel_q[SYNC_STAGES-2:0], bus.bus_bytesel_i};
         num_q[0]  <= bus.bus_reg_num_i;
         din_q[0]  <= bus.bus_data_i;
         for (int i = 1; i < SYNC_STAGES; i++) begin
            num_q[i] <= num_q[i-1];
            din_q[i] <= din_q[i-1];
         end
      end
   end

   assign cs_s = ~cs_n_q[SYNC_STAGES-1];

   logic [1:0]             state;
   logic [SYNC_STAGES-1:0] flushed;
   logic                   armed;
   logic                   wr_q;
   logic                   rd_q;
   logic                   dtack_q;
   logic                   oe_q;
   logic [DATA_W-1:0]      dout_q;
   logic [REGNUM_W-1:0]    num_o_q;
   logic                   bs_o_q;
   logic [DATA_W-1:0]      dat_o_q;

`ifdef XOSERA_BUS_TIMEOUT_EN
   localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
   logic [CNT_W-1:0] cnt;
   logic             to_q;
`endif

   // armed: a CS held across reset must be seen released first
   always_ff @(posedge clk or negedge reset_n_i) begin
      if (!reset_n_i) begin
         state   <= IDLE;
         flushed <= '0;
         armed   <= 1'b0;
         wr_q    <= 1'b0;
         rd_q    <= 1'b0;
         dtack_q <= 1'b0;
         oe_q    <= 1'b0;
         dout_q  <= '0;
         num_o_q <= '0;
         bs_o_q  <= 1'b0;
         dat_o_q <= '0;
`ifdef XOSERA_BUS_TIMEOUT_EN
         cnt     <= '0;
         to_q    <= 1'b0;
`endif
      end else begin
         wr_q    <= 1'b0;
         rd_q    <= 1'b0;
         flushed <= {flushed[SYNC_STAGES-2:0], 1'b1};
         if (flushed[SYNC_STAGES-1] && !cs_s)
            armed <= 1'b1;
         case (state)
            IDLE: begin
               if (cs_s && armed)
                  state <= SETTLE;
            end
            SETTLE: begin
               if (!cs_s) begin
                  state <= IDLE;
               end else begin
                  num_o_q <= num_q[SYNC_STAGES-1];
                  bs_o_q  <= bytesel_q[SYNC_STAGES-1];
                  dat_o_q <= din_q[SYNC_STAGES-1];
                  if (rd_nwr_q[SYNC_STAGES-1]) begin
                     rd_q  <= 1'b1;
                     state <= WAIT_RD;
`ifdef XOSERA_BUS_TIMEOUT_EN
                     cnt   <= '0;
`endif
                  end else begin
                     wr_q    <= 1'b1;
                     dtack_q <= 1'b1;
                     state   <= ACK;
                  end
               end
            end
            WAIT_RD: begin
               if (!cs_s) begin
                  state <= IDLE;
               end else if (bus.reg_rd_ack_i) begin
                  dout_q  <= bus.reg_rd_data_i;
                  dtack_q <= 1'b1;
                  oe_q    <= 1'b1;
                  state   <= ACK;
               end
`ifdef XOSERA_BUS_TIMEOUT_EN
               else if (cnt == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                  dout_q  <= '1;
                  dtack_q <= 1'b1;
                  oe_q    <= 1'b1;
                  to_q    <= 1'b1;
                  state   <= ACK;
               end else begin
                  cnt <= cnt + 1'b1;
               end
`endif
            end
            ACK: begin
               if (!cs_s) begin
                  dtack_q <= 1'b0;
                  oe_q    <= 1'b0;
                  state   <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign bus.bus_data_o    = dout_q;
   assign bus.bus_out_ena_o = oe_q;
   assign bus.bus_dtack_o   = dtack_q;
   assign bus.reg_wr_o      = wr_q;
   assign bus.reg_rd_o      = rd_q;
   assign bus.reg_num_o     = num_o_q;
   assign bus.reg_bytesel_o = bs_o_q;
   assign bus.reg_data_o    = dat_o_q;

`ifdef XOSERA_BUS_TIMEOUT_EN
   assign bus.bus_timeout_o = to_q;
`else
   assign bus.bus_timeout_o = (TIMEOUT_CYCLES < 0);
`endif

endmodule

// File: tb/tb_xosera_bus_if.sv
// Scoreboard bench for xosera_bus_if: stimulus queues expected events,
// a negedge monitor pops and compares strobes and DTACK edges.
module tb_xosera_bus_if;

   localparam int DW = 8;
   localparam int RW = 4;
   localparam int TO = 8;

   localparam int K_WR = 0;
   localparam int K_RD = 1;
   localparam int K_DR = 2;
   localparam int K_DF = 3;

   typedef struct {
      int kind;
      int cyc;
      int a;
      int b;
      int c;
   } ev_t;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   int   cyc   = 0;
   int   n_cmp = 0;
   int   n_bad = 0;
   ev_t  q[$];

   int   ack_dly  = -1;
   int   ack_dat  = 0;
   int   pend     = -1;
   int   late_at  = -1;
   int   late_dat = 0;
   int   last_rd  = 0;
   int   exp_to   = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   xosera_bus_if_if #(.DATA_W(DW), .REGNUM_W(RW)) bif ();

   xosera_bus_if #(
      .DATA_W(DW),
      .REGNUM_W(RW),
      .SYNC_STAGES(2),
      .TIMEOUT_CYCLES(TO)
   ) dut (
      .clk(clk),
      .reset_n_i(rst_n),
      .bus(bif)
   );

   function automatic string nm(input int k);
      case (k)
         K_WR:    return "reg_wr";
         K_RD:    return "reg_rd";
         K_DR:    return "dtack_rise";
         default: return "dtack_fall";
      endcase
   endfunction

   task automatic push(input int k, input int c, input int a,
                       input int b, input int cc);
      ev_t e;
      e.kind = k;
      e.cyc  = c;
      e.a    = a;
      e.b    = b;
      e.c    = cc;
      q.push_back(e);
   endtask

   task automatic take(input int k, input int a, input int b,
                       input int c);
      ev_t e;
      n_cmp++;
      if (q.size() == 0) begin
         n_bad++;
         $display("FAIL %s unexpected: got cyc=%0d a=%0h b=%0h c=%0h, required no event",
                  nm(k), cyc, a, b, c);
         return;
      end
      e = q.pop_front();
      if (e.kind != k || e.cyc != cyc || e.a != a ||
          e.b != b || e.c != c) begin
         n_bad++;
         $display("FAIL %s: got kind=%0d cyc=%0d a=%0h b=%0h c=%0h, required kind=%0d cyc=%0d a=%0h b=%0h c=%0h",
                  nm(k), k, cyc, a, b, c,
                  e.kind, e.cyc, e.a, e.b, e.c);
      end
   endtask

   task automatic chk(input string n, input int act, input int exp);
      n_cmp++;
      if (act != exp) begin
         n_bad++;
         $display("FAIL %s: got %0h, required %0h", n, act, exp);
      end
   endtask

   // core model: one-cycle ack ack_dly cycles after reg_rd_o
   initial begin
      bif.reg_rd_ack_i  = 1'b0;
      bif.reg_rd_data_i = '0;
      forever begin
         @(negedge clk);
         bif.reg_rd_ack_i = 1'b0;
         if (bif.reg_rd_o && ack_dly >= 0)
            pend = ack_dly;
         if (pend == 0) begin
            bif.reg_rd_ack_i  = 1'b1;
            bif.reg_rd_data_i = DW'(ack_dat);
            pend = -1;
         end else if (pend > 0) begin
            pend--;
         end
         if (cyc == late_at) begin
            bif.reg_rd_ack_i  = 1'b1;
            bif.reg_rd_data_i = DW'(late_dat);
         end
      end
   end

   logic dt_prev = 1'b0;

   initial begin
      forever begin
         @(negedge clk);
         if (rst_n) begin
            if (bif.reg_wr_o)
               take(K_WR, int'(bif.reg_num_o),
                    int'(bif.reg_bytesel_o), int'(bif.reg_data_o));
            if (bif.reg_rd_o)
               take(K_RD, int'(bif.reg_num_o),
                    int'(bif.reg_bytesel_o), 0);
            if (bif.bus_dtack_o && !dt_prev)
               take(K_DR, int'(bif.bus_data_o),
                    int'(bif.bus_out_ena_o), int'(bif.bus_timeout_o));
            if (!bif.bus_dtack_o && dt_prev)
               take(K_DF, int'(bif.bus_out_ena_o), 0, 0);
            dt_prev = bif.bus_dtack_o;
         end else begin
            dt_prev = 1'b0;
         end
      end
   end

   task automatic start(input logic rd, input int num, input int bs,
                        input int dat, output int d);
      @(negedge clk);
      bif.bus_rd_nwr_i  = rd;
      bif.bus_reg_num_i = RW'(num);
      bif.bus_bytesel_i = bs[0];
      bif.bus_data_i    = DW'(dat);
      bif.bus_cs_n_i    = 1'b0;
      d = cyc;
   endtask

   task automatic release_cs(input int hold);
      repeat (hold) @(negedge clk);
      bif.bus_cs_n_i = 1'b1;
      push(K_DF, cyc + 3, 0, 0, 0);
      repeat (5) @(negedge clk);
   endtask

   task automatic do_write(input int num, input int bs, input int dat);
      int d;
      start(1'b0, num, bs, dat, d);
      push(K_WR, d + 4, num, bs, dat);
      push(K_DR, d + 4, last_rd, 0, exp_to);
      release_cs(7);
   endtask

   task automatic do_read(input int num, input int bs, input int dly,
                          input int dat);
      int d;
      ack_dly = dly;
      ack_dat = dat;
      start(1'b1, num, bs, 0, d);
      push(K_RD, d + 4, num, bs, 0);
      push(K_DR, d + 5 + dly, dat, 1, exp_to);
      last_rd = dat;
      release_cs(dly + 8);
      ack_dly = -1;
   endtask

   task automatic chk_all_zero(input string n);
      chk({n, "_dtack"}, int'(bif.bus_dtack_o), 0);
      chk({n, "_oe"}, int'(bif.bus_out_ena_o), 0);
      chk({n, "_data"}, int'(bif.bus_data_o), 0);
      chk({n, "_wr_rd"}, int'({bif.reg_wr_o, bif.reg_rd_o}), 0);
      chk({n, "_regs"}, int'({bif.reg_num_o, bif.reg_bytesel_o,
                               bif.reg_data_o}), 0);
      chk({n, "_timeout"}, int'(bif.bus_timeout_o), 0);
   endtask

   initial begin
      int d;
      bif.bus_cs_n_i    = 1'b1;
      bif.bus_rd_nwr_i  = 1'b0;
      bif.bus_bytesel_i = 1'b0;
      bif.bus_reg_num_i = '0;
      bif.bus_data_i    = '0;

      #23;
      chk_all_zero("reset");
      @(negedge clk);
      rst_n = 1'b1;
      repeat (5) @(negedge clk);

      do_write(3, 1, 8'hA5);
      do_read(7, 0, 3, 8'h5C);
      do_read(2, 1, 0, 8'h11);

      // abort in WAIT_RD, then a late ack that must be ignored
      start(1'b1, 4, 0, 0, d);
      push(K_RD, d + 4, 4, 0, 0);
      repeat (6) @(negedge clk);
      bif.bus_cs_n_i = 1'b1;
      late_at  = cyc + 5;
      late_dat = 8'hEE;
      repeat (10) @(negedge clk);
      chk("abort_data", int'(bif.bus_data_o), last_rd);
      chk("abort_dtack", int'(bif.bus_dtack_o), 0);
      chk("abort_oe", int'(bif.bus_out_ena_o), 0);
      do_write(5, 0, 8'h42);

      // reset while a read waits for ack, CS still held afterwards
      start(1'b1, 6, 1, 0, d);
      push(K_RD, d + 4, 6, 1, 0);
      repeat (6) @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      chk_all_zero("rst_mid");
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      last_rd = 0;
      repeat (12) @(negedge clk);
      chk("held_cs_idle", int'({bif.bus_dtack_o, bif.reg_rd_o}), 0);
      chk("held_cs_queue", q.size(), 0);
      bif.bus_cs_n_i = 1'b1;
      repeat (4) @(negedge clk);
      do_write(9, 1, 8'h3C);
      do_read(1, 0, 1, 8'h96);

`ifdef XOSERA_BUS_TIMEOUT_EN
      start(1'b1, 8, 0, 0, d);
      push(K_RD, d + 4, 8, 0, 0);
      push(K_DR, d + 4 + TO, 8'hFF, 1, 1);
      last_rd = 8'hFF;
      exp_to  = 1;
      release_cs(TO + 8);
      do_write(2, 0, 8'h77);
      chk("timeout_sticky", int'(bif.bus_timeout_o), 1);
`else
      chk("timeout_off", int'(bif.bus_timeout_o), 0);
`endif

      repeat (4) @(negedge clk);
      chk("queue_drained", q.size(), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***",
               n_cmp, n_bad);
      $finish;
   end

endmodule
